// File: rtl/posit_argmax_if.sv
// Stream bundle for posit_argmax: posit words in, argmax result out.
// Signal names follow the DUT's view (_i driven by the producer, _o by the DUT).
interface posit_argmax_if #(
   parameter int POSIT_WIDTH = 16,
   parameter int INDEX_WIDTH = 4
);
   logic                   rtr_o;
   logic                   rts_i;
   logic                   eow_i;
   logic [POSIT_WIDTH-1:0] posit_i;
   logic                   rtr_i;
   logic                   rts_o;
   logic                   eow_o;
   logic [INDEX_WIDTH-1:0] index_o;
   logic [POSIT_WIDTH-1:0] max_o;

   modport slave (
      output rtr_o, rts_o, eow_o, index_o, max_o,
      input  rts_i, eow_i, posit_i, rtr_i
   );

   modport master (
      input  rtr_o, rts_o, eow_o, index_o, max_o,
      output rts_i, eow_i, posit_i, rtr_i
   );
endinterface

// File: rtl/posit_argmax.sv
// Frame-wise argmax over a posit stream; one registered result per frame,
// with the end-of-DMA marker carried through to the result.
module posit_argmax #(
   parameter int NB_CLASSES  = 10,
   parameter int POSIT_WIDTH = 16,
   parameter int POSIT_ES    = 0,
   parameter int INDEX_WIDTH = $clog2(NB_CLASSES)
) (
   input  logic          clk,
   input  logic          rst_n,
   posit_argmax_if.slave bus
);

   if (NB_CLASSES < 2 || POSIT_ES < 0) begin : g_param_check
      $error("posit_argmax: NB_CLASSES must be >= 2 and POSIT_ES >= 0");
   end

   localparam logic [INDEX_WIDTH-1:0] LAST = INDEX_WIDTH'(NB_CLASSES - 1);

   typedef enum logic {ACCUM, EMIT} state_t;

   state_t                 state, state_nxt;
   logic [INDEX_WIDTH-1:0] wc, cur_idx, nxt_idx, index_q;
   logic [POSIT_WIDTH-1:0] cur_max, nxt_max, max_q;
   logic                   rts_q, eow_q, dma_last, rtr;
   logic                   accept, take, frame_end, out_ack;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ACCUM;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ACCUM:   if (frame_end)  state_nxt = EMIT;
         EMIT:    if (bus.rtr_i)  state_nxt = ACCUM;
         default:                 state_nxt = ACCUM;
      endcase
   end

   always_comb begin
      rtr = (state == ACCUM);
   end

   // Signed compare orders posits correctly; NaR lands at the bottom.
   // Strict '>' keeps the lowest index on ties; wc==0 always seeds the frame.
   always_comb begin
      accept    = bus.rts_i & rtr;
      take      = (wc == '0) || ($signed(bus.posit_i) > $signed(cur_max));
      nxt_max   = take ? bus.posit_i : cur_max;
      nxt_idx   = take ? wc : cur_idx;
      frame_end = accept & ((wc == LAST) | bus.eow_i);
      out_ack   = rts_q & bus.rtr_i;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wc       <= '0;
         cur_idx  <= '0;
         cur_max  <= '0;
         index_q  <= '0;
         max_q    <= '0;
         rts_q    <= 1'b0;
         eow_q    <= 1'b0;
         dma_last <= 1'b0;
      end else begin
         if (accept) begin
            cur_max <= nxt_max;
            cur_idx <= nxt_idx;
            wc      <= frame_end ? '0 : wc + 1'b1;
            if (bus.eow_i) dma_last <= 1'b1;
         end
         if (frame_end) begin
            index_q <= nxt_idx;
            max_q   <= nxt_max;
            eow_q   <= bus.eow_i | dma_last;
            rts_q   <= 1'b1;
         end
         if (out_ack) begin
            rts_q <= 1'b0;
            eow_q <= 1'b0;
            if (eow_q) dma_last <= 1'b0;
         end
      end
   end

   assign bus.rtr_o   = rtr;
   assign bus.rts_o   = rts_q;
   assign bus.eow_o   = eow_q;
   assign bus.index_o = index_q;
   assign bus.max_o   = max_q;

endmodule
